// File: rtl/amba_axi_pkg.sv
// AXI4 channel bundles, ID type and burst/size/response encodings shared by
// the AXI managers and subordinates on the core-side interconnect.
package amba_axi_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ID_W   = 4;

   typedef logic [AXI_ID_W-1:0]     axi_tid_t;
   typedef logic [AXI_ADDR_W-1:0]   axi_addr_t;
   typedef logic [AXI_DATA_W-1:0]   axi_data_t;
   typedef logic [AXI_DATA_W/8-1:0] axi_strb_t;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [2:0] AXI_SIZE_1B = 3'b000;
   localparam logic [2:0] AXI_SIZE_2B = 3'b001;
   localparam logic [2:0] AXI_SIZE_4B = 3'b010;
   localparam logic [2:0] AXI_SIZE_8B = 3'b011;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef struct packed {
      axi_tid_t   awid;
      axi_addr_t  awaddr;
      logic [7:0] awlen;
      logic [2:0] awsize;
      logic [1:0] awburst;
      logic       awlock;
      logic [3:0] awcache;
      logic [2:0] awprot;
      logic       awvalid;
      axi_data_t  wdata;
      axi_strb_t  wstrb;
      logic       wlast;
      logic       wvalid;
      logic       bready;
      axi_tid_t   arid;
      axi_addr_t  araddr;
      logic [7:0] arlen;
      logic [2:0] arsize;
      logic [1:0] arburst;
      logic       arlock;
      logic [3:0] arcache;
      logic [2:0] arprot;
      logic       arvalid;
      logic       rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic       awready;
      logic       wready;
      axi_tid_t   bid;
      logic [1:0] bresp;
      logic       bvalid;
      logic       arready;
      axi_tid_t   rid;
      axi_data_t  rdata;
      logic [1:0] rresp;
      logic       rlast;
      logic       rvalid;
   } s_axi_miso_t;

endpackage

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4 manager: one request becomes one single-beat read or write.
// Response is a registered one-cycle pulse (>=3 cycles with zero-wait responders); req_ready only in IDLE.
module axi_lite_initiator
   import amba_axi_pkg::*;
#(
   parameter axi_tid_t AXI_ID   = '0,
   parameter bit       CHECK_ID = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output s_axi_mosi_t axi_mosi,
   input  s_axi_miso_t axi_miso,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_done;
   logic        w_done;
   logic        aw_done_nxt;
   logic        w_done_nxt;
   logic        resp_valid_nxt;
   logic        resp_error_nxt;
   logic [31:0] resp_rdata_nxt;
   logic        accept;
   logic        aw_hs;
   logic        w_hs;
   logic        bid_bad;
   logic        rid_bad;
   logic        unused_miso_bits;

   // rlast is meaningless for single-beat reads; only bit 1 of a response marks an error.
   assign unused_miso_bits = ^{axi_miso.rlast, axi_miso.bresp[0], axi_miso.rresp[0]};

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign aw_hs     = axi_mosi.awvalid && axi_miso.awready;
   assign w_hs      = axi_mosi.wvalid && axi_miso.wready;
   assign bid_bad   = CHECK_ID && (axi_miso.bid != AXI_ID);
   assign rid_bad   = CHECK_ID && (axi_miso.rid != AXI_ID);

   always_comb begin
      axi_mosi         = '0;
      axi_mosi.awid    = AXI_ID;
      axi_mosi.awaddr  = addr_q;
      axi_mosi.awlen   = 8'd0;
      axi_mosi.awsize  = AXI_SIZE_4B;
      axi_mosi.awburst = AXI_BURST_INCR;
      axi_mosi.awvalid = (state == ST_WR) && !aw_done;
      axi_mosi.wdata   = wdata_q;
      axi_mosi.wstrb   = wstrb_q;
      axi_mosi.wlast   = 1'b1;
      axi_mosi.wvalid  = (state == ST_WR) && !w_done;
      axi_mosi.bready  = (state == ST_WR_RESP);
      axi_mosi.arid    = AXI_ID;
      axi_mosi.araddr  = addr_q;
      axi_mosi.arlen   = 8'd0;
      axi_mosi.arsize  = AXI_SIZE_4B;
      axi_mosi.arburst = AXI_BURST_INCR;
      axi_mosi.arvalid = (state == ST_RD_ADDR);
      axi_mosi.rready  = (state == ST_RD_DATA);
   end

   always_comb begin
      state_nxt      = state;
      aw_done_nxt    = aw_done;
      w_done_nxt     = w_done;
      resp_valid_nxt = 1'b0;
      resp_error_nxt = 1'b0;
      resp_rdata_nxt = resp_rdata;
      unique case (state)
         ST_IDLE: begin
            if (req_valid) begin
               state_nxt   = req_we ? ST_WR : ST_RD_ADDR;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end
         end
         ST_WR: begin
            // AW and W complete independently; leave once both have, including this cycle.
            if (aw_hs) aw_done_nxt = 1'b1;
            if (w_hs)  w_done_nxt  = 1'b1;
            if (aw_done_nxt && w_done_nxt) state_nxt = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (axi_miso.bvalid) begin
               resp_valid_nxt = 1'b1;
               resp_error_nxt = axi_miso.bresp[1] | bid_bad;
               resp_rdata_nxt = '0;
               state_nxt      = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (axi_miso.arready) state_nxt = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (axi_miso.rvalid) begin
               resp_valid_nxt = 1'b1;
               resp_error_nxt = axi_miso.rresp[1] | rid_bad;
               resp_rdata_nxt = axi_miso.rdata;
               state_nxt      = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state      <= state_nxt;
         aw_done    <= aw_done_nxt;
         w_done     <= w_done_nxt;
         resp_valid <= resp_valid_nxt;
         resp_error <= resp_error_nxt;
         resp_rdata <= resp_rdata_nxt;
         // Payload only moves in IDLE, so it is stable for as long as any valid is high.
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Randomized bench for axi_lite_initiator: a responder with configurable stalls/errors
// plus a transaction-level model of the request/AXI/response contract, checked every cycle.
module tb_axi_lite_initiator;
   import amba_axi_pkg::*;

   localparam axi_tid_t    TB_ID      = 4'd3;
   localparam logic [31:0] TIMER_BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst;
   s_axi_mosi_t axi_mosi;
   s_axi_mosi_t axi_mosi_nc;
   s_axi_miso_t axi_miso;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        req_ready,  req_ready_nc;
   logic        resp_valid, resp_valid_nc;
   logic        resp_error, resp_error_nc;
   logic [31:0] resp_rdata, resp_rdata_nc;

   always #5 clk = ~clk;

   axi_lite_initiator #(.AXI_ID(TB_ID), .CHECK_ID(1'b1)) dut (
      .clk(clk), .rst(rst), .axi_mosi(axi_mosi), .axi_miso(axi_miso),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
   );

   // Same traffic, ID checking disabled: only the error flag may differ.
   axi_lite_initiator #(.AXI_ID(TB_ID), .CHECK_ID(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .axi_mosi(axi_mosi_nc), .axi_miso(axi_miso),
      .req_valid(req_valid), .req_ready(req_ready_nc), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid_nc), .resp_rdata(resp_rdata_nc), .resp_error(resp_error_nc)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // responder configuration
   int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   axi_tid_t    cfg_id = TB_ID;
   bit          cfg_ovr = 1'b0, cfg_stray = 1'b0;
   logic [31:0] cfg_ovr_dat = '0;
   logic [31:0] mem [16];

   // responder state
   int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
   bit          b_pend, r_pend;
   logic [31:0] r_addr;
   s_axi_miso_t drv;

   // transaction model
   bit          busy, m_we, aw_done, w_done, ar_done;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   bit          resp_due, due_rd, was_due, rst_prev;
   logic        due_err, due_err_nc;
   logic [31:0] due_rdata;
   bit          hs_aw, hs_w, hs_ar, hs_b, hs_r;

   // observed results
   int          resp_count = 0, b2b_count = 0, accept_cyc = 0, last_lat = 0;
   logic        last_err, last_err_nc;
   logic [31:0] last_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst_prev) begin
         chk("rst_awvalid", axi_mosi.awvalid, 0);
         chk("rst_wvalid", axi_mosi.wvalid, 0);
         chk("rst_bready", axi_mosi.bready, 0);
         chk("rst_arvalid", axi_mosi.arvalid, 0);
         chk("rst_rready", axi_mosi.rready, 0);
         chk("rst_req_ready", req_ready, 1);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_error", resp_error, 0);
         chk("rst_resp_rdata", resp_rdata, 0);
      end
      rst_prev = rst;
      if (rst) begin
         busy = 0; resp_due = 0; aw_done = 0; w_done = 0; ar_done = 0;
         b_pend = 0; r_pend = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
         axi_miso = '0;
      end else begin
         drv = '0;
         drv.awready = axi_mosi.awvalid && (aw_wait >= cfg_aw_dly);
         drv.wready  = axi_mosi.wvalid && (w_wait >= cfg_w_dly);
         drv.arready = axi_mosi.arvalid && (ar_wait >= cfg_ar_dly);
         if (b_pend) begin
            drv.bvalid = (b_wait >= cfg_b_dly);
            drv.bresp  = cfg_bresp;
            drv.bid    = cfg_id;
         end else if (cfg_stray) begin
            drv.bvalid = 1'b1;
            drv.bresp  = AXI_RESP_SLVERR;
         end
         if (r_pend) begin
            drv.rvalid = (r_wait >= cfg_r_dly);
            drv.rdata  = cfg_ovr ? cfg_ovr_dat : mem[r_addr[5:2]];
            drv.rresp  = cfg_rresp;
            drv.rid    = cfg_id;
            drv.rlast  = 1'b1;
         end else if (cfg_stray) begin
            drv.rvalid = 1'b1;
            drv.rdata  = 32'hBAD0_0BAD;
         end
         axi_miso = drv;

         chk("req_ready", req_ready, !busy);
         chk("resp_valid", resp_valid, resp_due);
         chk("nc_req_ready", req_ready_nc, !busy);
         chk("nc_resp_valid", resp_valid_nc, resp_due);
         total++;
         if (axi_mosi_nc !== axi_mosi) begin
            bad++;
            $display("FAIL mosi_nc: got %h expected %h", axi_mosi_nc, axi_mosi);
         end
         if (resp_due) begin
            chk("resp_error", resp_error, due_err);
            chk("nc_resp_error", resp_error_nc, due_err_nc);
            chk("resp_rdata", resp_rdata, due_rd ? due_rdata : 32'h0);
            resp_count++;
            last_err    = resp_error;
            last_err_nc = resp_error_nc;
            last_rdata  = resp_rdata;
            last_lat    = cyc - accept_cyc;
         end
         chk("awvalid", axi_mosi.awvalid, busy && m_we && !aw_done);
         chk("wvalid", axi_mosi.wvalid, busy && m_we && !w_done);
         chk("bready", axi_mosi.bready, busy && m_we && aw_done && w_done);
         chk("arvalid", axi_mosi.arvalid, busy && !m_we && !ar_done);
         chk("rready", axi_mosi.rready, busy && !m_we && ar_done);
         if (axi_mosi.awvalid) begin
            chk("awaddr", axi_mosi.awaddr, m_addr);
            chk("aw_fixed", {axi_mosi.awid, axi_mosi.awlen, axi_mosi.awsize, axi_mosi.awburst,
                             axi_mosi.awlock, axi_mosi.awcache, axi_mosi.awprot},
                {TB_ID, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0});
         end
         if (axi_mosi.wvalid) begin
            chk("wdata", axi_mosi.wdata, m_wdata);
            chk("wstrb", {axi_mosi.wstrb, axi_mosi.wlast}, {m_wstrb, 1'b1});
         end
         if (axi_mosi.arvalid) begin
            chk("araddr", axi_mosi.araddr, m_addr);
            chk("ar_fixed", {axi_mosi.arid, axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst,
                             axi_mosi.arlock, axi_mosi.arcache, axi_mosi.arprot},
                {TB_ID, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0});
         end

         hs_aw = axi_mosi.awvalid && drv.awready;
         hs_w  = axi_mosi.wvalid && drv.wready;
         hs_ar = axi_mosi.arvalid && drv.arready;
         hs_b  = axi_mosi.bready && drv.bvalid;
         hs_r  = axi_mosi.rready && drv.rvalid;
         was_due  = resp_due;
         resp_due = 0;

         if (axi_mosi.awvalid && !hs_aw) aw_wait++; else aw_wait = 0;
         if (axi_mosi.wvalid && !hs_w) w_wait++; else w_wait = 0;
         if (axi_mosi.arvalid && !hs_ar) ar_wait++; else ar_wait = 0;
         if (b_pend && !hs_b) b_wait++;
         if (r_pend && !hs_r) r_wait++;
         if (hs_w) begin
            for (int b = 0; b < 4; b++)
               if (m_wstrb[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
         end
         if (hs_aw) aw_done = 1;
         if (hs_w) w_done = 1;
         if ((hs_aw || hs_w) && aw_done && w_done) begin
            b_pend = 1; b_wait = 0;
         end
         if (hs_b) begin
            b_pend = 0; busy = 0; resp_due = 1; due_rd = 0;
            due_err    = drv.bresp[1] | (drv.bid != TB_ID);
            due_err_nc = drv.bresp[1];
         end
         if (hs_ar) begin
            ar_done = 1; r_pend = 1; r_wait = 0; r_addr = m_addr;
         end
         if (hs_r) begin
            r_pend = 0; busy = 0; resp_due = 1; due_rd = 1; due_rdata = drv.rdata;
            due_err    = drv.rresp[1] | (drv.rid != TB_ID);
            due_err_nc = drv.rresp[1];
         end
         if (req_valid && req_ready) begin
            if (was_due) b2b_count++;
            busy = 1; m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_wstrb = req_wstrb;
            aw_done = 0; w_done = 0; ar_done = 0; accept_cyc = cyc;
         end
      end
   end

   task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
      do begin
         @(negedge clk); #1; n++;
      end while (!req_ready && n < 400);
      if (!req_ready) chk("req_accept_timeout", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int tgt);
      int n = 0;
      while (resp_count < tgt && n < 400) begin
         @(negedge clk); #1; n++;
      end
      if (resp_count < tgt) chk("resp_timeout", resp_count, tgt);
   endtask

   task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int tgt = resp_count + 1;
      do_req(we, a, d, s);
      wait_resp(tgt);
   endtask

   task automatic set_dly(input int aw, input int w, input int ar, input int b, input int r);
      cfg_aw_dly = aw; cfg_w_dly = w; cfg_ar_dly = ar; cfg_b_dly = b; cfg_r_dly = r;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, b0, issued;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[4] = 32'h1;  // timer control word at +0x10 reads back 1 with timercmp cleared
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      txn(1'b1, TIMER_BASE + 32'h8, 32'h0000_1234, 4'hF);
      chk("wr8_err", last_err, 0);
      chk("wr8_latency", last_lat, 3);
      txn(1'b0, TIMER_BASE + 32'h8, 32'h0, 4'h0);
      chk("rd8_data", last_rdata, 32'h0000_1234);
      chk("rd8_err", last_err, 0);
      chk("rd8_latency", last_lat, 3);
      txn(1'b0, TIMER_BASE + 32'h10, 32'h0, 4'h0);
      chk("rd10_data", last_rdata, 32'h1);

      set_dly(3, 0, 0, 0, 0);
      txn(1'b1, TIMER_BASE + 32'hC, 32'hA5A5_0001, 4'hF);
      chk("aw_late_err", last_err, 0);
      set_dly(0, 3, 0, 0, 0);
      txn(1'b1, TIMER_BASE + 32'hC, 32'h0000_5A00, 4'h2);
      chk("w_late_err", last_err, 0);
      set_dly(0, 0, 0, 0, 0);
      txn(1'b1, TIMER_BASE + 32'h14, 32'h7777_7777, 4'hF);
      txn(1'b0, TIMER_BASE + 32'hC, 32'h0, 4'h0);
      chk("strb_merge", last_rdata, 32'hA5A5_5A01);

      cfg_bresp = AXI_RESP_SLVERR;
      txn(1'b1, TIMER_BASE, 32'h1, 4'hF);
      chk("slverr", last_err, 1);
      chk("slverr_nc", last_err_nc, 1);
      cfg_bresp = AXI_RESP_OKAY;
      cfg_rresp = AXI_RESP_DECERR; cfg_ovr = 1'b1; cfg_ovr_dat = 32'hDEAD_BEEF;
      txn(1'b0, TIMER_BASE, 32'h0, 4'h0);
      chk("decerr", last_err, 1);
      chk("decerr_rdata", last_rdata, 32'hDEAD_BEEF);
      cfg_rresp = AXI_RESP_OKAY; cfg_ovr = 1'b0;

      cfg_id = 4'd5;
      txn(1'b0, TIMER_BASE + 32'h10, 32'h0, 4'h0);
      chk("rid_bad_err", last_err, 1);
      chk("rid_bad_nc", last_err_nc, 0);
      cfg_id = TB_ID;

      c0 = resp_count;
      cfg_stray = 1'b1;
      repeat (6) @(posedge clk);
      #1 cfg_stray = 1'b0;
      chk("stray_no_resp", resp_count, c0);

      set_dly(6, 6, 0, 0, 0);
      do_req(1'b1, TIMER_BASE + 32'h20, 32'h1111_2222, 4'hF);
      chk("mid_awvalid", axi_mosi.awvalid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("rst_no_resp", resp_count, c0);
      set_dly(0, 0, 0, 0, 0);

      b0 = b2b_count;
      c0 = resp_count;
      do_req(1'b1, TIMER_BASE + 32'h24, 32'h0000_00C3, 4'hF);
      do_req(1'b0, TIMER_BASE + 32'h24, 32'h0, 4'h0);
      wait_resp(c0 + 2);
      chk("b2b_accept", b2b_count - b0, 1);
      chk("b2b_rdata", last_rdata, 32'h0000_00C3);

      c0 = resp_count;
      issued = 0;
      for (int i = 0; i < 80; i++) begin
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
         cfg_bresp = ($urandom_range(0, 5) == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         cfg_rresp = 2'($urandom_range(0, 3));
         cfg_id    = ($urandom_range(0, 6) == 0) ? 4'd5 : TB_ID;
         do_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
         issued++;
         if ($urandom_range(0, 1) == 1) wait_resp(c0 + issued);
      end
      wait_resp(c0 + issued);
      cfg_id = TB_ID;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
